// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit: 2-cycle MULT/MULTU, 33-cycle restoring DIV/DIVU,
// immediate MTHI/MTLO and combinational MFHI/MFLO read port.
module mul_div_unit #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exe_fire_in,
    input  logic [5:0]  exe_mult_div_op_in,
    input  logic        exe_read_request_in,
    input  logic        exe_read_hi_in,
    input  logic [31:0] exe_in0_in,
    input  logic [31:0] exe_in1_in,
    input  logic        cancel_in,
    output logic        md_ready_out,
    output logic        md_busy_out,
    output logic [31:0] md_rdata_out,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);
    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [31:0]             hi_q, lo_q;
    logic                    accept, signed_op, is_mul, is_div;

    logic                    op_signed_p0, q_neg_p0, r_neg_p0, dvz_p0;
    logic [31:0]             opa_p0, opb_p0;
    logic [31:0]             quo_p1, rem_p1, dvsr_p1;

    logic signed [63:0]      mul_a_ext, mul_b_ext, product;
    logic [32:0]             shifted;
    logic                    ge;
    logic [31:0]             quo_next, rem_next;

    function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? -x : x;
    endfunction

    function automatic logic [31:0] apply_sign(input logic [31:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    assign is_mul    = exe_mult_div_op_in[3] | exe_mult_div_op_in[2];
    assign is_div    = exe_mult_div_op_in[1] | exe_mult_div_op_in[0];
    assign signed_op = exe_mult_div_op_in[3] | exe_mult_div_op_in[1];
    assign accept    = exe_fire_in && (state_q == S_IDLE) && (exe_mult_div_op_in != 6'b0) && !cancel_in;

    assign md_busy_out  = (state_q != S_IDLE);
    assign md_ready_out = !md_busy_out || (exe_mult_div_op_in == 6'b0 && !exe_read_request_in);
    assign md_rdata_out = exe_read_hi_in ? hi_q : lo_q;
    assign hi_out       = hi_q;
    assign lo_out       = lo_q;

    // p0 -> MUL: sign/zero-extend to 64 bits so one multiplier serves both forms
    assign mul_a_ext = {{32{op_signed_p0 & opa_p0[31]}}, opa_p0};
    assign mul_b_ext = {{32{op_signed_p0 & opb_p0[31]}}, opb_p0};
    assign product   = mul_a_ext * mul_b_ext;

    // p1 -> DIV: one restoring step per cycle on magnitudes
    assign shifted  = {rem_p1, quo_p1[31]};
    assign ge       = (shifted >= {1'b0, dvsr_p1});
    assign rem_next = ge ? 32'(shifted - {1'b0, dvsr_p1}) : shifted[31:0];
    assign quo_next = {quo_p1[30:0], ge};

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cancel_in) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && is_mul)      state_d = S_MUL;
                    else if (accept && is_div) state_d = S_DIV;
                end
                S_MUL:  state_d = S_IDLE;
                S_DIV:  if (cnt_q == CNT_LAST) state_d = S_DONE;
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q  <= 32'h0;
            lo_q  <= 32'h0;
            cnt_q <= '0;
        end else if (cancel_in) begin
            cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && exe_mult_div_op_in[5]) hi_q <= exe_in0_in;
                    if (accept && exe_mult_div_op_in[4]) lo_q <= exe_in0_in;
                    cnt_q <= '0;
                end
                S_MUL: {hi_q, lo_q} <= product;
                S_DIV: cnt_q <= cnt_q + CNT_W'(1);
                S_DONE: begin
                    // Divide by zero bypasses sign fix-up: LO all ones, HI the raw dividend
                    lo_q <= dvz_p0 ? 32'hFFFF_FFFF : apply_sign(quo_p1, q_neg_p0);
                    hi_q <= dvz_p0 ? opa_p0        : apply_sign(rem_p1, r_neg_p0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_signed_p0 <= signed_op;
            opa_p0       <= exe_in0_in;
            opb_p0       <= exe_in1_in;
            q_neg_p0     <= signed_op & (exe_in0_in[31] ^ exe_in1_in[31]);
            r_neg_p0     <= signed_op & exe_in0_in[31];
            dvz_p0       <= (exe_in1_in == 32'h0);
            quo_p1       <= mag(exe_in0_in, signed_op);
            rem_p1       <= 32'h0;
            dvsr_p1      <= mag(exe_in1_in, signed_op);
        end else if (state_q == S_DIV) begin
            quo_p1 <= quo_next;
            rem_p1 <= rem_next;
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic reference model plus per-cycle compare.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        exe_fire_in;
    logic [5:0]  exe_mult_div_op_in;
    logic        exe_read_request_in;
    logic        exe_read_hi_in;
    logic [31:0] exe_in0_in;
    logic [31:0] exe_in1_in;
    logic        cancel_in;
    logic        md_ready_out;
    logic        md_busy_out;
    logic [31:0] md_rdata_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_vec = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    localparam logic [5:0] OP_MTHI = 6'b100000, OP_MTLO = 6'b010000, OP_MULT = 6'b001000,
                           OP_MULTU = 6'b000100, OP_DIV = 6'b000010, OP_DIVU = 6'b000001;

    always #5 clk = ~clk;

    assign exe_fire_in = ex_valid && md_ready_out;

    mul_div_unit #(.DIV_CYCLES(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .exe_fire_in         (exe_fire_in),
        .exe_mult_div_op_in  (exe_mult_div_op_in),
        .exe_read_request_in (exe_read_request_in),
        .exe_read_hi_in      (exe_read_hi_in),
        .exe_in0_in          (exe_in0_in),
        .exe_in1_in          (exe_in1_in),
        .cancel_in           (cancel_in),
        .md_ready_out        (md_ready_out),
        .md_busy_out         (md_busy_out),
        .md_rdata_out        (md_rdata_out),
        .hi_out              (hi_out),
        .lo_out              (lo_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mdl_mul(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        return 64'(sa * sb);
    endfunction

    // Returns {remainder, quotient}
    function automatic logic [63:0] mdl_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic signed [31:0] sa, sb;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            sa = a;
            sb = b;
            return {32'(sa % sb), 32'(sa / sb)};
        end
        return {a % b, a / b};
    endfunction

    // Reference model: architectural HI/LO plus cycles remaining until a pending result lands
    int          m_left;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;

    always @(posedge clk) begin
        if (rst) begin
            m_hi <= 32'h0; m_lo <= 32'h0; m_left <= 0;
        end else if (cancel_in) begin
            m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end else if (exe_fire_in && exe_mult_div_op_in != 6'b0) begin
            if (exe_mult_div_op_in[5]) m_hi <= exe_in0_in;
            if (exe_mult_div_op_in[4]) m_lo <= exe_in0_in;
            if (exe_mult_div_op_in[3] | exe_mult_div_op_in[2]) begin
                {p_hi, p_lo} <= mdl_mul(exe_in0_in, exe_in1_in, exe_mult_div_op_in[3]);
                m_left <= 1;
            end
            if (exe_mult_div_op_in[1] | exe_mult_div_op_in[0]) begin
                {p_hi, p_lo} <= mdl_div(exe_in0_in, exe_in1_in, exe_mult_div_op_in[1]);
                m_left <= 33;
            end
        end
    end

    always @(negedge clk) begin
        logic eb, er;
        if (chk_en) begin
            eb = (m_left > 0);
            er = !eb || (exe_mult_div_op_in == 6'b0 && !exe_read_request_in);
            check("busy", 32'(md_busy_out), 32'(eb));
            check("ready", 32'(md_ready_out), 32'(er));
            check("hi", hi_out, m_hi);
            check("lo", lo_out, m_lo);
            if (er && exe_read_request_in && exe_mult_div_op_in == 6'b0)
                check("rdata", md_rdata_out, exe_read_hi_in ? m_hi : m_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; exe_mult_div_op_in = 6'b0; exe_read_request_in = 1'b0;
        exe_read_hi_in = 1'b0; exe_in0_in = 32'h0; exe_in1_in = 32'h0; cancel_in = 1'b0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        ex_valid = 1'b1; exe_mult_div_op_in = op; exe_in0_in = a; exe_in1_in = b;
        tick();
        idle_inputs();
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 100; i++) begin
            if (!md_busy_out) break;
            tick();
        end
        check(name, 32'(md_busy_out), 32'h0);
    endtask

    initial begin
        int stall;
        rst = 1'b1;
        idle_inputs();
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset then MFHI / MFLO
        exe_read_request_in = 1'b1; exe_read_hi_in = 1'b1;
        @(negedge clk);
        check("t1_mfhi", md_rdata_out, 32'h0);
        check("t1_ready", 32'(md_ready_out), 32'h1);
        tick();
        exe_read_hi_in = 1'b0;
        @(negedge clk);
        check("t1_mflo", md_rdata_out, 32'h0);
        tick();
        idle_inputs();

        // MTHI then MFHI
        issue(OP_MTHI, 32'h1234_5678, 32'h0);
        exe_read_request_in = 1'b1; exe_read_hi_in = 1'b1;
        @(negedge clk);
        check("t2_mfhi", md_rdata_out, 32'h1234_5678);
        check("t2_lo", lo_out, 32'h0);
        tick();
        idle_inputs();

        // MULT / MULTU
        issue(OP_MULT, 32'hFFFF_FFFE, 32'h3);
        @(negedge clk);
        check("t3_mult_busy", 32'(md_busy_out), 32'h1);
        tick();
        @(negedge clk);
        check("t3_mult_idle", 32'(md_busy_out), 32'h0);
        check("t3_mult_hi", hi_out, 32'hFFFF_FFFF);
        check("t3_mult_lo", lo_out, 32'hFFFF_FFFA);
        tick();
        issue(OP_MULTU, 32'hFFFF_FFFE, 32'h3);
        tick();
        check("t3_multu_hi", hi_out, 32'h2);
        check("t3_multu_lo", lo_out, 32'hFFFF_FFFA);

        // DIV -7 / 2 with MFLO waiting behind it
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h2);
        exe_read_request_in = 1'b1; exe_read_hi_in = 1'b0; ex_valid = 1'b1;
        stall = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (md_ready_out) break;
            stall++;
        end
        check("t4_stall_cycles", 32'(stall), 32'd33);
        check("t4_mflo", md_rdata_out, 32'hFFFF_FFFD);
        check("t4_hi", hi_out, 32'hFFFF_FFFF);
        tick();
        idle_inputs();

        // DIVU 100 / 0, with an independent instruction flowing meanwhile
        issue(OP_DIVU, 32'd100, 32'h0);
        ex_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_add_not_stalled", 32'(md_ready_out), 32'h1);
            tick();
        end
        idle_inputs();
        wait_idle("t5_divz_timeout");
        check("t5_divz_lo", lo_out, 32'hFFFF_FFFF);
        check("t5_divz_hi", hi_out, 32'd100);

        // Signed overflow
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("t5_ovf_timeout");
        check("t5_ovf_lo", lo_out, 32'h8000_0000);
        check("t5_ovf_hi", hi_out, 32'h0);

        // DIVU 10 / 3 cancelled mid-flight, then MULTU 3 x 4
        issue(OP_DIVU, 32'd10, 32'd3);
        repeat (14) tick();
        cancel_in = 1'b1;
        tick();
        cancel_in = 1'b0;
        @(negedge clk);
        check("t6_cancel_idle", 32'(md_busy_out), 32'h0);
        check("t6_cancel_hi", hi_out, 32'h0);
        check("t6_cancel_lo", lo_out, 32'h8000_0000);
        tick();
        issue(OP_MULTU, 32'd3, 32'd4);
        tick();
        check("t6_multu_lo", lo_out, 32'd12);
        check("t6_multu_hi", hi_out, 32'h0);

        // An op alongside cancel is dropped
        ex_valid = 1'b1; exe_mult_div_op_in = OP_MTLO; exe_in0_in = 32'hDEAD_BEEF; cancel_in = 1'b1;
        tick();
        idle_inputs();
        check("t7_cancel_blocks_mt", lo_out, 32'd12);

        // Reset in the middle of a divide
        issue(OP_MTHI, 32'hA5A5_A5A5, 32'h0);
        issue(OP_DIVU, 32'd50, 32'd7);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t8_rst_busy", 32'(md_busy_out), 32'h0);
        check("t8_rst_hi", hi_out, 32'h0);
        check("t8_rst_lo", lo_out, 32'h0);
        tick(); tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
